// File: rtl/pattern_matcher_pkg.sv
// -----------------------------------------------------------------------------
// pattern_matcher_pkg
// Shared types and helpers for the streaming pattern matcher.
//   pm_state_t : load/arm state machine encoding
//   cnt_w(n)   : width of a counter that must hold the values 0..n
// -----------------------------------------------------------------------------
package pattern_matcher_pkg;

    typedef enum logic [1:0] {
        PM_EMPTY   = 2'd0,
        PM_LOADING = 2'd1,
        PM_FILL    = 2'd2,
        PM_RUN     = 2'd3
    } pm_state_t;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pm_shift_reg.sv
// -----------------------------------------------------------------------------
// pm_shift_reg
// Serial-in / parallel-out shift register. New bits enter at bit 0 and move
// toward bit W-1, so the first bit received ends up in the MSB.
// Ports:
//   clk      in  1  clock, rising edge
//   rnot     in  1  asynchronous active-low reset (loads RST_VAL)
//   clr      in  1  synchronous clear to zero; if shift_en is also high the
//                   incoming bit lands in bit 0 of the cleared register
//   shift_en in  1  shift one bit in
//   din      in  1  serial data
//   q        out W  parallel contents
// -----------------------------------------------------------------------------
module pm_shift_reg #(
    parameter int             W       = 8,
    parameter logic [W-1:0]   RST_VAL = {W{1'b0}}
) (
    input  logic         clk,
    input  logic         rnot,
    input  logic         clr,
    input  logic         shift_en,
    input  logic         din,
    output logic [W-1:0] q
);

    logic [W-1:0] q_r;
    logic [W-1:0] shifted_s;

    // Value after one shift step.
    always_comb begin
        shifted_s = {q_r[W-2:0], din};
    end

    // Register update: reset, clear (optionally with one bit in), or shift.
    always_ff @(posedge clk or negedge rnot) begin
        if (!rnot) begin
            q_r <= RST_VAL;
        end else if (clr) begin
            if (shift_en) begin
                q_r <= {{(W-1){1'b0}}, din};
            end else begin
                q_r <= {W{1'b0}};
            end
        end else if (shift_en) begin
            q_r <= shifted_s;
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/pattern_matcher.sv
// -----------------------------------------------------------------------------
// pattern_matcher
// Streaming detector: a serially programmed N-bit pattern is compared against
// an N-bit sliding window of a qualified serial signal. A load/arm FSM keeps
// partially loaded patterns and partially filled windows from matching.
// Optional build macro: MASK_EN adds a per-bit care register fed by prgm_care
// (care=0 positions are don't-care). Without it every bit is compared and
// prgm_care is ignored.
// Ports:
//   clk       in  1      clock, rising edge
//   rnot      in  1      asynchronous active-low reset
//   prgm_en   in  1      program strobe, one pattern bit per cycle
//   prgm_bit  in  1      pattern bit
//   prgm_care in  1      care bit (MASK_EN builds only)
//   sig_valid in  1      signal strobe, one window bit per cycle
//   sig_bit   in  1      signal bit
//   cnt_clr   in  1      synchronous clear of match_cnt
//   armed     out 1      pattern loaded and window full
//   match     out 1      one-cycle pulse per matching window
//   match_cnt out CNT_W  saturating match count
// -----------------------------------------------------------------------------
module pattern_matcher
    import pattern_matcher_pkg::*;
#(
    parameter int N     = 1024,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rnot,
    input  logic             prgm_en,
    input  logic             prgm_bit,
    input  logic             prgm_care,
    input  logic             sig_valid,
    input  logic             sig_bit,
    input  logic             cnt_clr,
    output logic             armed,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int              CW        = cnt_w(N);
    localparam logic [CW-1:0]   FULL_C    = CW'(N);
    localparam logic [CW-1:0]   LAST_C    = CW'(N - 1);
    localparam logic [CW-1:0]   ONE_C     = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]   ZERO_C    = {CW{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX_C = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE_C = {{(CNT_W-1){1'b0}}, 1'b1};

    pm_state_t          state_r;
    pm_state_t          next_state_s;
    logic [CW-1:0]      ld_cnt_r;
    logic [CW-1:0]      ld_cnt_nxt_s;
    logic [CW-1:0]      fill_cnt_r;
    logic [CW-1:0]      fill_cnt_nxt_s;

    logic [N-1:0]       pattern_s;
    logic [N-1:0]       window_s;
    logic [N-1:0]       next_window_s;
    logic [N-1:0]       diff_s;

    logic               prog_start_s;
    logic               win_shift_s;
    logic               eval_s;
    logic               hit_s;

    logic               armed_r;
    logic               match_r;
    logic [CNT_W-1:0]   match_cnt_r;
    logic [CNT_W-1:0]   match_cnt_nxt_s;

    // The window's MSB is shifted out and never compared directly.
    logic               unused_win_msb_s;
    assign unused_win_msb_s = window_s[N-1];

    // Strobe decode. A strobe outside LOADING starts a fresh load and throws
    // away the current window; programming always beats the signal strobe.
    always_comb begin
        prog_start_s = prgm_en && (state_r != PM_LOADING);
        win_shift_s  = sig_valid && !prgm_en &&
                       ((state_r == PM_FILL) || (state_r == PM_RUN));
        eval_s       = win_shift_s &&
                       ((state_r == PM_RUN) || (fill_cnt_r == LAST_C));
    end

    pm_shift_reg #(
        .W       (N),
        .RST_VAL ({N{1'b0}})
    ) u_pattern (
        .clk      (clk),
        .rnot     (rnot),
        .clr      (1'b0),
        .shift_en (prgm_en),
        .din      (prgm_bit),
        .q        (pattern_s)
    );

    pm_shift_reg #(
        .W       (N),
        .RST_VAL ({N{1'b0}})
    ) u_window (
        .clk      (clk),
        .rnot     (rnot),
        .clr      (prog_start_s),
        .shift_en (win_shift_s),
        .din      (sig_bit),
        .q        (window_s)
    );

`ifdef MASK_EN
    logic [N-1:0] care_s;

    pm_shift_reg #(
        .W       (N),
        .RST_VAL ({N{1'b1}})
    ) u_care (
        .clk      (clk),
        .rnot     (rnot),
        .clr      (1'b0),
        .shift_en (prgm_en),
        .din      (prgm_care),
        .q        (care_s)
    );

    // Compare the post-shift window, ignoring don't-care positions.
    always_comb begin
        next_window_s = {window_s[N-2:0], sig_bit};
        diff_s        = (next_window_s ^ pattern_s) & care_s;
        hit_s         = eval_s && (diff_s == {N{1'b0}});
    end
`else
    logic unused_prgm_care_s;
    assign unused_prgm_care_s = prgm_care;

    // Compare the post-shift window against every pattern bit.
    always_comb begin
        next_window_s = {window_s[N-2:0], sig_bit};
        diff_s        = next_window_s ^ pattern_s;
        hit_s         = eval_s && (diff_s == {N{1'b0}});
    end
`endif

    // Load/arm FSM next-state and counter updates.
    always_comb begin
        next_state_s   = state_r;
        ld_cnt_nxt_s   = ld_cnt_r;
        fill_cnt_nxt_s = fill_cnt_r;
        case (state_r)
            PM_EMPTY, PM_FILL, PM_RUN: begin
                if (prog_start_s) begin
                    next_state_s   = PM_LOADING;
                    ld_cnt_nxt_s   = ONE_C;
                    fill_cnt_nxt_s = ZERO_C;
                end else if (win_shift_s && (state_r == PM_FILL)) begin
                    if (fill_cnt_r != FULL_C) begin
                        fill_cnt_nxt_s = fill_cnt_r + ONE_C;
                    end else begin
                        fill_cnt_nxt_s = fill_cnt_r;
                    end
                    if (fill_cnt_r == LAST_C) begin
                        next_state_s = PM_RUN;
                    end else begin
                        next_state_s = PM_FILL;
                    end
                end else begin
                    next_state_s = state_r;
                end
            end
            PM_LOADING: begin
                if (prgm_en) begin
                    if (ld_cnt_r != FULL_C) begin
                        ld_cnt_nxt_s = ld_cnt_r + ONE_C;
                    end else begin
                        ld_cnt_nxt_s = ld_cnt_r;
                    end
                    if (ld_cnt_r == LAST_C) begin
                        next_state_s = PM_FILL;
                    end else begin
                        next_state_s = PM_LOADING;
                    end
                end else begin
                    next_state_s = PM_LOADING;
                end
            end
            default: begin
                next_state_s   = PM_EMPTY;
                ld_cnt_nxt_s   = ZERO_C;
                fill_cnt_nxt_s = ZERO_C;
            end
        endcase
    end

    // Saturating match counter; a clear coinciding with a hit leaves one.
    always_comb begin
        if (cnt_clr) begin
            if (hit_s) begin
                match_cnt_nxt_s = CNT_ONE_C;
            end else begin
                match_cnt_nxt_s = {CNT_W{1'b0}};
            end
        end else if (hit_s && (match_cnt_r != CNT_MAX_C)) begin
            match_cnt_nxt_s = match_cnt_r + CNT_ONE_C;
        end else begin
            match_cnt_nxt_s = match_cnt_r;
        end
    end

    // FSM state and load/fill counters.
    always_ff @(posedge clk or negedge rnot) begin
        if (!rnot) begin
            state_r    <= PM_EMPTY;
            ld_cnt_r   <= ZERO_C;
            fill_cnt_r <= ZERO_C;
        end else begin
            state_r    <= next_state_s;
            ld_cnt_r   <= ld_cnt_nxt_s;
            fill_cnt_r <= fill_cnt_nxt_s;
        end
    end

    // Registered outputs; armed follows the state being entered on this edge.
    always_ff @(posedge clk or negedge rnot) begin
        if (!rnot) begin
            armed_r     <= 1'b0;
            match_r     <= 1'b0;
            match_cnt_r <= {CNT_W{1'b0}};
        end else begin
            armed_r     <= (next_state_s == PM_RUN);
            match_r     <= hit_s;
            match_cnt_r <= match_cnt_nxt_s;
        end
    end

    assign armed     = armed_r;
    assign match     = match_r;
    assign match_cnt = match_cnt_r;

endmodule

// File: tb/tb_pattern_matcher.sv
// -----------------------------------------------------------------------------
// tb_pattern_matcher
// Bench for pattern_matcher at N=8, CNT_W=2. A bit-queue style reference model
// tracks the loaded pattern, the window contents and the match count; every
// cycle the DUT outputs are compared against it, and the directed scenarios
// also check explicit expected values.
// -----------------------------------------------------------------------------
module tb_pattern_matcher;

    localparam int N     = 8;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rnot;
    logic             prgm_en;
    logic             prgm_bit;
    logic             prgm_care;
    logic             sig_valid;
    logic             sig_bit;
    logic             cnt_clr;
    logic             armed;
    logic             match;
    logic [CNT_W-1:0] match_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    logic [7:0] m_pat;
    logic [7:0] m_care;
    logic [7:0] m_win;
    int         m_ld;
    int         m_fill;
    bit         m_loading;
    bit         m_ready;
    int         m_cnt;
    bit         m_hit;

    pattern_matcher #(.N(N), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rnot      (rnot),
        .prgm_en   (prgm_en),
        .prgm_bit  (prgm_bit),
        .prgm_care (prgm_care),
        .sig_valid (sig_valid),
        .sig_bit   (sig_bit),
        .cnt_clr   (cnt_clr),
        .armed     (armed),
        .match     (match),
        .match_cnt (match_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit windows_equal(input logic [7:0] w, input logic [7:0] p, input logic [7:0] c);
`ifdef MASK_EN
        return ((w ^ p) & c) == 8'h00;
`else
        return (w == p) && (c == c);
`endif
    endfunction

    task automatic model_reset();
        m_pat = 8'h00; m_care = 8'hFF; m_win = 8'h00;
        m_ld = 0; m_fill = 0; m_loading = 0; m_ready = 0; m_cnt = 0; m_hit = 0;
    endtask

    task automatic model_step(input bit pe, input bit pb, input bit pc,
                              input bit sv, input bit sb, input bit clr);
        m_hit = 0;
        if (pe) begin
            if (!m_loading) begin
                m_loading = 1; m_ready = 0; m_ld = 0; m_fill = 0; m_win = 8'h00;
            end
            m_pat  = {m_pat[6:0], pb};
            m_care = {m_care[6:0], pc};
            m_ld++;
            if (m_ld == N) begin
                m_loading = 0;
                m_ready   = 1;
            end
        end else if (sv && m_ready) begin
            m_win = {m_win[6:0], sb};
            if (m_fill < N) m_fill++;
            if (m_fill == N) m_hit = windows_equal(m_win, m_pat, m_care);
        end
        if (clr) m_cnt = m_hit ? 1 : 0;
        else if (m_hit && m_cnt < (1 << CNT_W) - 1) m_cnt++;
    endtask

    // One clock: drive inputs, step model, compare all outputs.
    task automatic cyc(input bit pe, input bit pb, input bit pc,
                       input bit sv, input bit sb, input bit clr);
        prgm_en = pe; prgm_bit = pb; prgm_care = pc;
        sig_valid = sv; sig_bit = sb; cnt_clr = clr;
        @(posedge clk);
        #1;
        model_step(pe, pb, pc, sv, sb, clr);
        check_eq("armed", armed, (m_ready && m_fill == N) ? 1 : 0);
        check_eq("match", match, m_hit);
        check_eq("match_cnt", match_cnt, m_cnt);
    endtask

    task automatic prog(input logic [7:0] pat, input logic [7:0] care, input bit noise);
        for (int i = 7; i >= 0; i--)
            cyc(1'b1, pat[i], care[i], noise ? 1'($urandom_range(0, 1)) : 1'b0,
                1'($urandom_range(0, 1)), 1'b0);
    endtask

    task automatic stream(input logic [7:0] v, input int nbits);
        for (int i = 0; i < nbits; i++)
            cyc(1'b0, 1'b0, 1'b0, 1'b1, v[7 - i], 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_cnt[4] = '{1, 2, 3, 3};
        logic [7:0] pat;
        logic [7:0] care;
        int idx;

        rnot = 1'b0; prgm_en = 1'b0; prgm_bit = 1'b0; prgm_care = 1'b0;
        sig_valid = 1'b0; sig_bit = 1'b0; cnt_clr = 1'b0;
        model_reset();
        #12;
        check_eq("rst_armed", armed, 0);
        check_eq("rst_match", match, 0);
        check_eq("rst_cnt", match_cnt, 0);
        rnot = 1'b1;

        // partial window: 7 bits never arm or match
        prog(8'hA5, 8'hFF, 1'b0);
        stream(8'hA5, 7);
        check_eq("partial_armed", armed, 0);
        check_eq("partial_cnt", match_cnt, 0);

        // exact match, back-to-back, saturation
        prog(8'hA5, 8'hFF, 1'b0);
        for (int r = 0; r < 4; r++) begin
            stream(8'hA5, 8);
            check_eq("b2b_match", match, 1);
            check_eq("b2b_armed", armed, 1);
            check_eq("b2b_cnt", match_cnt, exp_cnt[r]);
        end

        // reprogram in RUN with sig_valid overlapping
        pat = 8'h3C;
        cyc(1'b1, pat[7], 1'b1, 1'b1, 1'b1, 1'b0);
        check_eq("reprog_armed", armed, 0);
        check_eq("reprog_match", match, 0);
        for (int i = 6; i >= 0; i--) cyc(1'b1, pat[i], 1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
        stream(8'h3C, 8);
        check_eq("reprog_hit", match, 1);
        check_eq("reprog_cnt", match_cnt, 3);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("clr_cnt", match_cnt, 0);

        // care mask
        prog(8'hA0, 8'hF0, 1'b0);
        stream(8'hAF, 8);
`ifdef MASK_EN
        check_eq("mask_match", match, 1);
`else
        check_eq("mask_match", match, 0);
`endif

        // asynchronous reset between edges
        prog(8'hA5, 8'hFF, 1'b0);
        stream(8'hA5, 8);
        check_eq("pre_rst_armed", armed, 1);
        #2 rnot = 1'b0;
        #1;
        check_eq("arst_armed", armed, 0);
        check_eq("arst_match", match, 0);
        check_eq("arst_cnt", match_cnt, 0);
        #2 rnot = 1'b1;
        model_reset();
        stream(8'hA5, 8);
        check_eq("post_rst_armed", armed, 0);
        check_eq("post_rst_cnt", match_cnt, 0);

        // randomized: stream mostly the loaded pattern with bit flips
        for (int r = 0; r < 25; r++) begin
            pat  = 8'($urandom);
            care = 8'($urandom);
            prog(pat, care, 1'b1);
            idx = 0;
            for (int k = 0; k < 60; k++) begin
                bit pe, sv, flip, clr, sb;
                pe   = ($urandom_range(0, 99) < 2);
                sv   = ($urandom_range(0, 99) < 75);
                flip = ($urandom_range(0, 99) < 10);
                clr  = ($urandom_range(0, 99) < 5);
                sb   = pat[7 - (idx % 8)] ^ flip;
                if (sv) idx++;
                cyc(pe, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), sv, sb, clr);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
